axis_pipe_register: RTL and testbench

//  Parametrised AXI-Stream pipeline register: a chain of STAGES full-throughput skid-buffer

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_skid_stage.sv | 107 ++++++++++
 rtl/axis_pipe_register.sv | 75 +++++++
 tb/tb_axis_pipe_register.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream pipeline register.
// stage_state_t is visible to benches and assertions.
package axis_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // tdata width in bits for a given byte count
    function automatic int axis_data_w(input int bytes);
        return bytes * 8;
    endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One full-throughput AXI-Stream skid stage: main register drives the output,
// skid register catches the beat accepted while the output was stalled.
// Optional sideband: define AXIS_PIPE_TUSER_EN to carry tuser (one bit per byte).
module axis_skid_stage
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES = 1
)
(
    input  logic                                clk,
    input  logic                                sreset,
    output logic                                axis_i_tready,
    input  logic                                axis_i_tvalid,
    input  logic                                axis_i_tlast,
    input  logic [axis_data_w(AXIS_BYTES)-1:0]  axis_i_tdata,
`ifdef AXIS_PIPE_TUSER_EN
    input  logic [AXIS_BYTES-1:0]               axis_i_tuser,
    output logic [AXIS_BYTES-1:0]               axis_o_tuser,
`endif
    input  logic                                axis_o_tready,
    output logic                                axis_o_tvalid,
    output logic                                axis_o_tlast,
    output logic [axis_data_w(AXIS_BYTES)-1:0]  axis_o_tdata
);

    localparam int DW = axis_data_w(AXIS_BYTES);
`ifdef AXIS_PIPE_TUSER_EN
    localparam int PW = 1 + DW + AXIS_BYTES;
`else
    localparam int PW = 1 + DW;
`endif

    stage_state_t    state_q, state_d;
    logic            in_tready_q;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_payload;
    logic            in_fire;
    logic            out_fire;

`ifdef AXIS_PIPE_TUSER_EN
    assign in_payload   = {axis_i_tlast, axis_i_tdata, axis_i_tuser};
    assign axis_o_tuser = main_q[AXIS_BYTES-1:0];
    assign axis_o_tdata = main_q[AXIS_BYTES +: DW];
`else
    assign in_payload   = {axis_i_tlast, axis_i_tdata};
    assign axis_o_tdata = main_q[DW-1:0];
`endif
    assign axis_o_tlast = main_q[PW-1];

    // Ready comes from a flop; reset masks it so nothing is taken while sreset is high
    assign axis_i_tready = in_tready_q & ~sreset;
    assign axis_o_tvalid = (state_q != EMPTY);
    assign in_fire       = axis_i_tvalid & axis_i_tready;
    assign out_fire      = axis_o_tvalid & axis_o_tready;

    // Next state and register loads for main/skid
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_payload;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_payload;
                end else if (in_fire) begin
                    skid_d  = in_payload;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_fire cannot happen here: ready is low while FULL
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control flops; ready is precomputed from the next state so it drops as the skid fills
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= EMPTY;
            in_tready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_tready_q <= (state_d != FULL);
        end
    end

    // Payload flops carry no reset; validity lives entirely in state_q
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/axis_pipe_register.sv
// AXI-Stream pipeline register: a chain of STAGES skid stages (STAGES=0 is a wire).
// Optional sideband: define AXIS_PIPE_TUSER_EN to add axis_i_tuser/axis_o_tuser.
module axis_pipe_register
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES = 1,
    parameter int STAGES     = 1
)
(
    input  logic                                clk,
    input  logic                                sreset,
    output logic                                axis_i_tready,
    input  logic                                axis_i_tvalid,
    input  logic                                axis_i_tlast,
    input  logic [axis_data_w(AXIS_BYTES)-1:0]  axis_i_tdata,
`ifdef AXIS_PIPE_TUSER_EN
    input  logic [AXIS_BYTES-1:0]               axis_i_tuser,
    output logic [AXIS_BYTES-1:0]               axis_o_tuser,
`endif
    input  logic                                axis_o_tready,
    output logic                                axis_o_tvalid,
    output logic                                axis_o_tlast,
    output logic [axis_data_w(AXIS_BYTES)-1:0]  axis_o_tdata
);

    localparam int DW = axis_data_w(AXIS_BYTES);

    // Node k sits between stage k-1 and stage k; node 0 is the input, node STAGES the output.
    // With STAGES=0 the two ends are the same node, giving a pure wire path.
    logic            ready_w [STAGES+1];
    logic            valid_w [STAGES+1];
    logic            last_w  [STAGES+1];
    logic [DW-1:0]   data_w  [STAGES+1];
`ifdef AXIS_PIPE_TUSER_EN
    logic [AXIS_BYTES-1:0] user_w [STAGES+1];

    assign user_w[0]    = axis_i_tuser;
    assign axis_o_tuser = user_w[STAGES];
`endif

    assign valid_w[0]      = axis_i_tvalid;
    assign last_w[0]       = axis_i_tlast;
    assign data_w[0]       = axis_i_tdata;
    assign axis_i_tready   = ready_w[0];

    assign ready_w[STAGES] = axis_o_tready;
    assign axis_o_tvalid   = valid_w[STAGES];
    assign axis_o_tlast    = last_w[STAGES];
    assign axis_o_tdata    = data_w[STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            axis_skid_stage #(
                .AXIS_BYTES (AXIS_BYTES)
            ) u_stage (
                .clk           (clk),
                .sreset        (sreset),
                .axis_i_tready (ready_w[gi]),
                .axis_i_tvalid (valid_w[gi]),
                .axis_i_tlast  (last_w[gi]),
                .axis_i_tdata  (data_w[gi]),
`ifdef AXIS_PIPE_TUSER_EN
                .axis_i_tuser  (user_w[gi]),
                .axis_o_tuser  (user_w[gi+1]),
`endif
                .axis_o_tready (ready_w[gi+1]),
                .axis_o_tvalid (valid_w[gi+1]),
                .axis_o_tlast  (last_w[gi+1]),
                .axis_o_tdata  (data_w[gi+1])
            );
        end
    endgenerate

endmodule

// File: tb/tb_axis_pipe_register.sv
// Bench for axis_pipe_register: reset, streaming, backpressure, random traffic,
// mid-packet reset and STAGES=0 pass-through. Define AXIS_PIPE_TUSER_EN to include tuser.
`timescale 1ns/1ps
module tb_axis_pipe_register;

    logic clk = 1'b0;
    logic sreset;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
        logic [3:0]  user;
    } beat_t;

    beat_t sb[$];

    // STAGES=2, 4 bytes
    logic        d2_itready, d2_itvalid, d2_itlast;
    logic [31:0] d2_itdata;
    logic        d2_otready, d2_otvalid, d2_otlast;
    logic [31:0] d2_otdata;
    // STAGES=3, 1 byte
    logic        d3_itready, d3_itvalid, d3_itlast;
    logic [7:0]  d3_itdata;
    logic        d3_otready, d3_otvalid, d3_otlast;
    logic [7:0]  d3_otdata;
    // STAGES=0, 8 bytes
    logic        d0_itready, d0_itvalid, d0_itlast;
    logic [63:0] d0_itdata;
    logic        d0_otready, d0_otvalid, d0_otlast;
    logic [63:0] d0_otdata;
`ifdef AXIS_PIPE_TUSER_EN
    logic [3:0]  d2_ituser, d2_otuser;
    logic [0:0]  d3_ituser, d3_otuser;
    logic [7:0]  d0_ituser, d0_otuser;
`endif

    axis_pipe_register #(.AXIS_BYTES(4), .STAGES(2)) u_dut2 (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(d2_itready), .axis_i_tvalid(d2_itvalid),
        .axis_i_tlast(d2_itlast), .axis_i_tdata(d2_itdata),
`ifdef AXIS_PIPE_TUSER_EN
        .axis_i_tuser(d2_ituser), .axis_o_tuser(d2_otuser),
`endif
        .axis_o_tready(d2_otready), .axis_o_tvalid(d2_otvalid),
        .axis_o_tlast(d2_otlast), .axis_o_tdata(d2_otdata)
    );

    axis_pipe_register #(.AXIS_BYTES(1), .STAGES(3)) u_dut3 (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(d3_itready), .axis_i_tvalid(d3_itvalid),
        .axis_i_tlast(d3_itlast), .axis_i_tdata(d3_itdata),
`ifdef AXIS_PIPE_TUSER_EN
        .axis_i_tuser(d3_ituser), .axis_o_tuser(d3_otuser),
`endif
        .axis_o_tready(d3_otready), .axis_o_tvalid(d3_otvalid),
        .axis_o_tlast(d3_otlast), .axis_o_tdata(d3_otdata)
    );

    axis_pipe_register #(.AXIS_BYTES(8), .STAGES(0)) u_dut0 (
        .clk(clk), .sreset(sreset),
        .axis_i_tready(d0_itready), .axis_i_tvalid(d0_itvalid),
        .axis_i_tlast(d0_itlast), .axis_i_tdata(d0_itdata),
`ifdef AXIS_PIPE_TUSER_EN
        .axis_i_tuser(d0_ituser), .axis_o_tuser(d0_otuser),
`endif
        .axis_o_tready(d0_otready), .axis_o_tvalid(d0_otvalid),
        .axis_o_tlast(d0_otlast), .axis_o_tdata(d0_otdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Streams n_beats through the STAGES=2 instance with random valid/ready duty,
    // scoreboarding every accepted beat and checking output stability while stalled.
    task automatic run_dut2(input int n_beats, input int vpct, input int rpct,
                            input int max_cycles, input logic [31:0] base,
                            output int first_in, output int first_out, output int last_out);
        int    sent = 0;
        int    got  = 0;
        int    cyc  = 0;
        logic  hold = 1'b0;
        beat_t held = '0;
        beat_t e;
        beat_t o;
        first_in  = -1;
        first_out = -1;
        last_out  = -1;
        while (got < n_beats && cyc < max_cycles) begin
            @(negedge clk);
            if (hold) begin
                check("hold_valid", d2_otvalid, 1'b1);
                check("hold_payload", {d2_otlast, d2_otdata}, {held.last, held.data});
            end
            d2_itvalid = (sent < n_beats) && ($urandom_range(99) < vpct);
            d2_itdata  = base + 32'(sent);
            d2_itlast  = (sent % 7 == 6);
`ifdef AXIS_PIPE_TUSER_EN
            d2_ituser  = d2_itdata[3:0] ^ 4'h5;
`endif
            d2_otready = ($urandom_range(99) < rpct);
            #1;
            if (d2_itvalid && d2_itready) begin
                e.last = d2_itlast;
                e.data = d2_itdata;
`ifdef AXIS_PIPE_TUSER_EN
                e.user = d2_ituser;
`else
                e.user = 4'h0;
`endif
                sb.push_back(e);
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            o.last = d2_otlast;
            o.data = d2_otdata;
`ifdef AXIS_PIPE_TUSER_EN
            o.user = d2_otuser;
`else
            o.user = 4'h0;
`endif
            if (d2_otvalid && d2_otready) begin
                if (sb.size() == 0) begin
                    check("spurious_beat", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("data", o.data, e.data);
                    check("last", o.last, e.last);
`ifdef AXIS_PIPE_TUSER_EN
                    check("user", o.user, e.user);
`endif
                end
                $display("beat %0d: data=%08h last=%0b", got, o.data, o.last);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            hold = d2_otvalid && !d2_otready;
            held = o;
            cyc++;
        end
        @(posedge clk);
        #1;
        d2_itvalid = 1'b0;
        d2_otready = 1'b0;
        check("beats_out", got, n_beats);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vec_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fi, fo, lo;
        int acc, n;
        logic [63:0] exp_data;

        sreset = 1'b1;
        d2_itvalid = 1'b1; d2_itlast = 1'b0; d2_itdata = '0; d2_otready = 1'b0;
        d3_itvalid = 1'b1; d3_itlast = 1'b0; d3_itdata = '0; d3_otready = 1'b0;
        d0_itvalid = 1'b0; d0_itlast = 1'b0; d0_itdata = '0; d0_otready = 1'b0;
`ifdef AXIS_PIPE_TUSER_EN
        d2_ituser = '0; d3_ituser = '0; d0_ituser = '0;
`endif

        // Reset held for 3 edges with input valid asserted
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_d2_ovalid", d2_otvalid, 1'b0);
            check("rst_d2_iready", d2_itready, 1'b0);
            check("rst_d3_ovalid", d3_otvalid, 1'b0);
            check("rst_d3_iready", d3_itready, 1'b0);
        end
        sreset = 1'b0;
        d2_itvalid = 1'b0;
        d3_itvalid = 1'b0;
        @(negedge clk);
        check("rel_d2_iready", d2_itready, 1'b1);
        check("rel_d3_iready", d3_itready, 1'b1);
        check("rel_d2_ovalid", d2_otvalid, 1'b0);

        // Streaming: 100 beats, output always ready
        run_dut2(100, 100, 100, 400, 32'h0, fi, fo, lo);
        check("latency", 64'(fo - fi), 64'd2);
        check("one_per_cycle", 64'(lo - fo), 64'd99);

        // Backpressure on STAGES=3: exactly 6 beats absorbed
        acc = 0;
        d3_otready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            d3_itvalid = 1'b1;
            d3_itdata  = 8'(acc);
            d3_itlast  = 1'b0;
            #1;
            if (d3_itvalid && d3_itready) acc++;
        end
        @(negedge clk);
        check("bp_accepted", acc, 6);
        check("bp_iready_low", d3_itready, 1'b0);
        d3_itvalid = 1'b0;
        d3_otready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            #1;
            if (d3_otvalid && d3_otready) begin
                check("bp_order", d3_otdata, 64'(n));
                $display("drain %0d: data=%02h", n, d3_otdata);
                n++;
            end
            @(negedge clk);
        end
        check("bp_drained", n, 6);
        d3_otready = 1'b0;

        // Randomised traffic
        run_dut2(10000, 50, 50, 60000, 32'hA000_0000, fi, fo, lo);

        // Fill STAGES=2 completely, then reset for one cycle
        acc = 0;
        d2_otready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            d2_itvalid = 1'b1;
            d2_itdata  = 32'hDEAD_0000 + 32'(c);
            d2_itlast  = 1'b0;
            #1;
            if (d2_itvalid && d2_itready) acc++;
        end
        @(negedge clk);
        check("fill_accepted", acc, 4);
        d2_itvalid = 1'b0;
        sreset = 1'b1;
        #1;
        check("midrst_iready", d2_itready, 1'b0);
        @(negedge clk);
        sreset = 1'b0;
        check("midrst_ovalid", d2_otvalid, 1'b0);
        d2_otready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_stale", d2_otvalid, 1'b0);
        end
        d2_otready = 1'b0;
        run_dut2(20, 100, 100, 200, 32'h5000_0000, fi, fo, lo);

        // STAGES=0 pass-through across all valid/ready combinations
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_data   = {$urandom, $urandom};
            d0_itvalid = k[0];
            d0_otready = k[1];
            d0_itlast  = k[0] ^ k[1];
            d0_itdata  = exp_data;
`ifdef AXIS_PIPE_TUSER_EN
            d0_ituser  = 8'hA5;
`endif
            #1;
            check("pt_tvalid", d0_otvalid, 64'(k[0]));
            check("pt_tready", d0_itready, 64'(k[1]));
            check("pt_tlast", d0_otlast, 64'(k[0] ^ k[1]));
            check("pt_tdata", d0_otdata, exp_data);
`ifdef AXIS_PIPE_TUSER_EN
            check("pt_tuser", d0_otuser, 64'hA5);
`endif
            $display("passthru %0d: valid=%0b ready=%0b data=%016h", k, d0_otvalid, d0_itready, d0_otdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
